// File: rtl/rotate_restore_if.sv
// Valid/ready bundle between the rotator output register, the restore block and the display path.
interface rotate_restore_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             in_dir;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_dir, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_dir, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/rotate_restore.sv
// Undoes a circular rotation two positions per clock (one for the final odd step),
// then holds the restored word until the consumer takes it.
module rotate_restore #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input logic             clk,
  input logic             reset,
  rotate_restore_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] amt_mod;
  logic [WIDTH-1:0] rotl1, rotl2, rotr1, rotr2;

  // Only matters when AMT_W is widened beyond what WIDTH needs.
  assign amt_mod = AMT_W'(32'(bus.in_amt) % WIDTH);

  assign rotl1 = {word_q[WIDTH-2:0], word_q[WIDTH-1]};
  assign rotl2 = {word_q[WIDTH-3:0], word_q[WIDTH-1:WIDTH-2]};
  assign rotr1 = {word_q[0], word_q[WIDTH-1:1]};
  assign rotr2 = {word_q[1:0], word_q[WIDTH-1:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // dir=1 means the word was rotated right, so it is undone by rotating left.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          count_d = amt_mod;
          dir_d   = bus.in_dir;
          state_d = (amt_mod == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        if (count_q >= AMT_W'(2)) begin
          word_d  = dir_q ? rotl2 : rotr2;
          count_d = count_q - AMT_W'(2);
        end else begin
          word_d  = dir_q ? rotl1 : rotr1;
          count_d = count_q - AMT_W'(1);
        end
        if (count_d == '0) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = word_q;

endmodule

// File: tb/tb_rotate_restore.sv
// Directed and round-trip checks of rotate_restore against a timeline model of
// when each restored word must appear.
module tb_rotate_restore;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rotate_restore_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  rotate_restore #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model state: a pending transaction, edges elapsed since its accept, and its expected result.
  bit               started     = 1'b0;
  bit               pending     = 1'b0;
  bit               after_reset = 1'b0;
  int               age         = 0;
  int               edges_req   = 0;
  logic [WIDTH-1:0] exp_data    = '0;

  function automatic logic [WIDTH-1:0] restore_ref(logic [WIDTH-1:0] w, int k, logic dir);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dir) r[(i + k) % WIDTH] = w[i];
      else     r[i] = w[(i + k) % WIDTH];
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rotate_ref(logic [WIDTH-1:0] w, int k, logic dir);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (dir) r[i] = w[(i + k) % WIDTH];
      else     r[(i + k) % WIDTH] = w[i];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      started     <= 1'b1;
      pending     <= 1'b0;
      after_reset <= 1'b1;
    end else if (started) begin
      if (pending) begin
        if (age >= edges_req && bus.out_ready) pending <= 1'b0;
        else age <= age + 1;
      end else if (bus.in_valid) begin
        pending     <= 1'b1;
        age         <= 0;
        edges_req   <= (int'(bus.in_amt) + 1) / 2;
        exp_data    <= restore_ref(bus.in_data, int'(bus.in_amt), bus.in_dir);
        after_reset <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      checkOutput("in_ready", 32'(bus.in_ready), 32'(!pending));
      checkOutput("busy", 32'(bus.busy), 32'(pending));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(pending && age >= edges_req));
      if (pending && age >= edges_req)
        checkOutput("out_data", 32'(bus.out_data), 32'(exp_data));
      if (after_reset && !pending)
        checkOutput("out_data_after_reset", 32'(bus.out_data), 32'(0));
    end
  end

  // Latency counts cycles from the accept cycle to the first cycle with out_valid high.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input int amt, input logic dir,
                               output logic [WIDTH-1:0] got, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard == 100) reportTimeout("in_ready_wait");
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_amt   = AMT_W'(amt);
    bus.in_dir   = dir;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat == 40) reportTimeout("out_valid_wait");
    got = bus.out_data;
  endtask

  initial begin
    logic [WIDTH-1:0] got, orig, rot, held;
    int               lat, k;
    logic             dir;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_dir    = 1'b0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'(1));
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("reset_busy", 32'(bus.busy), 32'(0));
    checkOutput("reset_out_data", 32'(bus.out_data), 32'(0));

    checkOutput("model_pin_a", 32'(restore_ref(16'h8001, 3, 1'b1)), 32'(16'h000C));
    checkOutput("model_pin_b", 32'(restore_ref(16'h0003, 2, 1'b0)), 32'(16'hC000));
    checkOutput("model_pin_c", 32'(rotate_ref(16'h0002, 15, 1'b0)), 32'(16'h0001));

    applyStimulus(16'h0001, 1, 1'b1, got, lat);
    checkOutput("t1_data", 32'(got), 32'(16'h0002));
    checkOutput("t1_latency", 32'(lat), 32'(2));
    @(posedge clk); #1;
    checkOutput("t1_in_ready_after", 32'(bus.in_ready), 32'(1));

    applyStimulus(16'h8001, 3, 1'b1, got, lat);
    checkOutput("t2_data", 32'(got), 32'(16'h000C));
    checkOutput("t2_latency", 32'(lat), 32'(3));
    applyStimulus(16'h0003, 2, 1'b0, got, lat);
    checkOutput("t3_data", 32'(got), 32'(16'hC000));
    checkOutput("t3_latency", 32'(lat), 32'(2));

    applyStimulus(16'hBEEF, 0, 1'b1, got, lat);
    checkOutput("t4_data", 32'(got), 32'(16'hBEEF));
    checkOutput("t4_latency", 32'(lat), 32'(1));
    applyStimulus(16'h0001, 15, 1'b0, got, lat);
    checkOutput("t5_data", 32'(got), 32'(16'h0002));
    checkOutput("t5_latency", 32'(lat), 32'(9));

    // Backpressure with ignored input pulses while holding.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(16'h00F0, 4, 1'b0, held, lat);
    checkOutput("bp_data", 32'(held), 32'(16'h000F));
    checkOutput("bp_latency", 32'(lat), 32'(3));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 16'h1234;
      bus.in_amt   = 4'd1;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'(1));
      checkOutput("bp_out_data_stable", 32'(bus.out_data), 32'(held));
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_in_ready_after", 32'(bus.in_ready), 32'(1));
    checkOutput("bp_out_valid_after", 32'(bus.out_valid), 32'(0));

    // Reset in the middle of a long restore.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hA5A5;
    bus.in_amt   = 4'd15;
    bus.in_dir   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("mid_reset_in_ready", 32'(bus.in_ready), 32'(1));
    checkOutput("mid_reset_out_valid", 32'(bus.out_valid), 32'(0));
    checkOutput("mid_reset_busy", 32'(bus.busy), 32'(0));
    checkOutput("mid_reset_out_data", 32'(bus.out_data), 32'(0));
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checkOutput("mid_reset_no_output", 32'(bus.out_valid), 32'(0));
    end
    applyStimulus(16'h1357, 5, 1'b1, got, lat);
    checkOutput("post_reset_data", 32'(got), 32'(16'h6AE2));
    checkOutput("post_reset_latency", 32'(lat), 32'(4));

    for (int n = 0; n < 1000; n++) begin
      orig = WIDTH'($urandom);
      k    = int'($urandom_range(0, WIDTH - 1));
      dir  = 1'($urandom_range(0, 1));
      rot  = rotate_ref(orig, k, dir);
      applyStimulus(rot, k, dir, got, lat);
      checkOutput("roundtrip_data", 32'(got), 32'(orig));
      checkOutput("roundtrip_latency", 32'(lat), 32'((k + 1) / 2 + 1));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
